// File: rtl/ysyx_25030085_csr_pkg.sv
// Shared definitions for the machine-mode CSR port.
// Contents:
//   - CSR addresses used by the trap sequencer (mstatus, mtvec, mepc, mcause)
//   - csr_wen encodings (none / write / set)
//   - mstatus field positions (MIE, MPIE, MPP)
//   - trap sequencer state enum
//   - mstatus_on_trap / mstatus_on_ret: the mstatus updates for trap entry
//     and return. These are pure functions so the CSR file can apply the
//     same transforms.
package ysyx_25030085_csr_pkg;

  localparam int MST_W = 32;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  localparam logic [1:0] CSR_WEN_NONE  = 2'b00;
  localparam logic [1:0] CSR_WEN_WRITE = 2'b01;
  localparam logic [1:0] CSR_WEN_SET   = 2'b10;

  localparam int MST_MIE    = 3;
  localparam int MST_MPIE   = 7;
  localparam int MST_MPP_LO = 11;
  localparam int MST_MPP_HI = 12;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_MST,
    ST_WR_MST,
    ST_WR_EPC,
    ST_WR_CAU,
    ST_RD_TVEC,
    ST_RD_EPC,
    ST_DONE
  } trap_state_e;

  // Trap entry: stash MIE in MPIE, disable interrupts, record M-mode in MPP.
  function automatic logic [MST_W-1:0] mstatus_on_trap(input logic [MST_W-1:0] mst);
    logic [MST_W-1:0] nxt;
    nxt                          = mst;
    nxt[MST_MPIE]                = mst[MST_MIE];
    nxt[MST_MIE]                 = 1'b0;
    nxt[MST_MPP_HI:MST_MPP_LO]   = 2'b11;
    return nxt;
  endfunction

  // Trap return: restore MIE from MPIE, set MPIE, drop MPP to the return level.
  function automatic logic [MST_W-1:0] mstatus_on_ret(input logic [MST_W-1:0] mst,
                                                      input logic [1:0]       mpp);
    logic [MST_W-1:0] nxt;
    nxt                          = mst;
    nxt[MST_MIE]                 = mst[MST_MPIE];
    nxt[MST_MPIE]                = 1'b1;
    nxt[MST_MPP_HI:MST_MPP_LO]   = mpp;
    return nxt;
  endfunction

endpackage

// File: rtl/ysyx_25030085_trap_seq.sv
// Trap sequencer: initiator side of the machine-mode CSR port.
// Turns an accepted ecall or mret into a series of single-cycle CSR
// reads/writes, stalls the core while busy, then pulses a PC redirect.
//
// Ports:
//   clk, rst_n        core clock, async active-low reset
//   req_valid/ready   trap request handshake (ready only in IDLE)
//   is_ecall/is_mret  request type; ecall wins if both are set
//   req_pc/req_cause  PC of the trapping instruction, mcause for ecall
//   busy              stall while a sequence is in progress
//   csr_addr/wen/     CSR access issued this cycle
//   csr_wdata
//   csr_rdata         combinational read data for csr_addr
//   redirect_valid/pc one-cycle fetch redirect; pc holds until next capture
//
// State | meaning
// ------+------------------------------------------------------------
// IDLE    | waiting for a request, req_ready=1
// RD_MST  | read mstatus
// WR_MST  | write transformed mstatus (trap or return form)
// WR_EPC  | ecall: write mepc with the captured PC
// WR_CAU  | ecall: write mcause with the captured cause
// RD_TVEC | ecall: read mtvec, latch base as redirect target
// RD_EPC  | mret: read mepc, latch as redirect target
// DONE    | redirect pulse, still busy; back to IDLE next edge
//
// All csr_* and redirect_* outputs are registers loaded with the values
// for the state being entered, so they depend only on state and captured
// data and have no combinational path from req_*.
module ysyx_25030085_trap_seq
  import ysyx_25030085_csr_pkg::*;
#(
  parameter int         DATA_W  = 32,
  parameter int         ADDR_W  = 12,
  parameter logic [1:0] RET_MPP = 2'b00
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              is_ecall,
  input  logic              is_mret,
  input  logic [DATA_W-1:0] req_pc,
  input  logic [DATA_W-1:0] req_cause,
  output logic              busy,
  output logic [ADDR_W-1:0] csr_addr,
  output logic [1:0]        csr_wen,
  output logic [DATA_W-1:0] csr_wdata,
  input  logic [DATA_W-1:0] csr_rdata,
  output logic              redirect_valid,
  output logic [DATA_W-1:0] redirect_pc
);

  trap_state_e       state;
  logic              mret_q;
  logic [DATA_W-1:0] pc_q;
  logic [DATA_W-1:0] cause_q;

  assign busy      = (state != ST_IDLE);
  assign req_ready = (state == ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      mret_q         <= 1'b0;
      pc_q           <= '0;
      cause_q        <= '0;
      csr_addr       <= '0;
      csr_wen        <= CSR_WEN_NONE;
      csr_wdata      <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      csr_wen        <= CSR_WEN_NONE;
      redirect_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          // A valid request with no type bit set is dropped.
          if (req_valid && (is_ecall || is_mret)) begin
            state     <= ST_RD_MST;
            mret_q    <= !is_ecall;
            pc_q      <= req_pc;
            cause_q   <= req_cause;
            csr_addr  <= ADDR_W'(CSR_MSTATUS);
            csr_wdata <= '0;
          end
        end
        ST_RD_MST: begin
          // The transformed read value is the only use of the old mstatus,
          // so it is captured directly as the next cycle's write data.
          state     <= ST_WR_MST;
          csr_addr  <= ADDR_W'(CSR_MSTATUS);
          csr_wen   <= CSR_WEN_WRITE;
          if (mret_q) begin
            csr_wdata <= DATA_W'(mstatus_on_ret(MST_W'(csr_rdata), RET_MPP));
          end else begin
            csr_wdata <= DATA_W'(mstatus_on_trap(MST_W'(csr_rdata)));
          end
        end
        ST_WR_MST: begin
          csr_addr <= ADDR_W'(CSR_MEPC);
          if (mret_q) begin
            state     <= ST_RD_EPC;
            csr_wdata <= '0;
          end else begin
            state     <= ST_WR_EPC;
            csr_wen   <= CSR_WEN_WRITE;
            csr_wdata <= pc_q;
          end
        end
        ST_WR_EPC: begin
          state     <= ST_WR_CAU;
          csr_addr  <= ADDR_W'(CSR_MCAUSE);
          csr_wen   <= CSR_WEN_WRITE;
          csr_wdata <= cause_q;
        end
        ST_WR_CAU: begin
          state     <= ST_RD_TVEC;
          csr_addr  <= ADDR_W'(CSR_MTVEC);
          csr_wdata <= '0;
        end
        ST_RD_TVEC: begin
          // Vectored mode bits are ignored: always jump to the base.
          state          <= ST_DONE;
          redirect_pc    <= csr_rdata & ~DATA_W'(3);
          redirect_valid <= 1'b1;
          csr_addr       <= '0;
          csr_wdata      <= '0;
        end
        ST_RD_EPC: begin
          state          <= ST_DONE;
          redirect_pc    <= csr_rdata;
          redirect_valid <= 1'b1;
          csr_addr       <= '0;
          csr_wdata      <= '0;
        end
        ST_DONE: begin
          state     <= ST_IDLE;
          csr_addr  <= '0;
          csr_wdata <= '0;
        end
        default: begin
          state     <= ST_IDLE;
          csr_addr  <= '0;
          csr_wdata <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_25030085_trap_seq.sv
module tb_ysyx_25030085_trap_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        is_ecall = 1'b0;
  logic        is_mret = 1'b0;
  logic [31:0] req_pc = '0;
  logic [31:0] req_cause = '0;
  logic        busy;
  logic [11:0] csr_addr;
  logic [1:0]  csr_wen;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  ysyx_25030085_trap_seq dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .is_ecall(is_ecall), .is_mret(is_mret),
    .req_pc(req_pc), .req_cause(req_cause),
    .busy(busy),
    .csr_addr(csr_addr), .csr_wen(csr_wen), .csr_wdata(csr_wdata), .csr_rdata(csr_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  // CSR file responder: combinational read, write/set on the clock edge.
  logic [31:0] r_mstatus = '0, r_mtvec = '0, r_mepc = '0, r_mcause = '0;
  int n_wr_cause = 0;

  always_comb begin
    case (csr_addr)
      12'h300: csr_rdata = r_mstatus;
      12'h305: csr_rdata = r_mtvec;
      12'h341: csr_rdata = r_mepc;
      12'h342: csr_rdata = r_mcause;
      default: csr_rdata = '0;
    endcase
  end

  always @(posedge clk) begin
    if (csr_wen == 2'b01 || csr_wen == 2'b10) begin
      case (csr_addr)
        12'h300: r_mstatus <= (csr_wen == 2'b10) ? (r_mstatus | csr_wdata) : csr_wdata;
        12'h305: r_mtvec   <= (csr_wen == 2'b10) ? (r_mtvec | csr_wdata) : csr_wdata;
        12'h341: r_mepc    <= (csr_wen == 2'b10) ? (r_mepc | csr_wdata) : csr_wdata;
        12'h342: r_mcause  <= (csr_wen == 2'b10) ? (r_mcause | csr_wdata) : csr_wdata;
        default: ;
      endcase
      if (csr_addr == 12'h342) n_wr_cause++;
    end
  end

  // Reference model: mstatus rules written as plain bit arithmetic.
  function automatic logic [31:0] m_trap(input logic [31:0] m);
    logic [31:0] mie;
    mie = (m >> 3) & 32'h1;
    return (m & ~32'h0000_1888) | (mie << 7) | 32'h0000_1800;
  endfunction

  function automatic logic [31:0] m_ret(input logic [31:0] m);
    logic [31:0] mpie;
    mpie = (m >> 7) & 32'h1;
    return (m & ~32'h0000_1888) | (mpie << 3) | 32'h0000_0080;
  endfunction

  // Expected per-cycle behaviour (index = cycles after the acceptance edge).
  logic [11:0] e_addr[16];
  logic [1:0]  e_wen[16];
  logic [31:0] e_wdata[16];
  logic        e_chk_addr[16], e_rv[16], e_busy[16], e_ready[16];
  logic [31:0] e_rpc;
  int          e_len;

  logic [11:0] o_addr[16];
  logic [1:0]  o_wen[16];
  logic [31:0] o_wdata[16], o_rpc[16];
  logic        o_rv[16], o_busy[16], o_ready[16];

  task automatic add_acc(inout int n, input logic [11:0] a, input logic [1:0] w, input logic [31:0] d);
    n++;
    e_addr[n] = a; e_wen[n] = w; e_wdata[n] = d; e_chk_addr[n] = 1'b1;
  endtask

  // Each request is a list of CSR accesses, then one DONE cycle, then IDLE.
  task automatic build_expect(input bit ec, input bit mr, input logic [31:0] pc, input logic [31:0] cause);
    int n;
    n = 0;
    for (int c = 0; c < 16; c++) begin
      e_addr[c] = '0; e_wen[c] = 2'b00; e_wdata[c] = '0;
      e_chk_addr[c] = 1'b0; e_rv[c] = 1'b0; e_busy[c] = 1'b1; e_ready[c] = 1'b0;
    end
    if (ec) begin
      add_acc(n, 12'h300, 2'b00, 32'h0);
      add_acc(n, 12'h300, 2'b01, m_trap(r_mstatus));
      add_acc(n, 12'h341, 2'b01, pc);
      add_acc(n, 12'h342, 2'b01, cause);
      add_acc(n, 12'h305, 2'b00, 32'h0);
      e_rpc = r_mtvec & ~32'h3;
    end else if (mr) begin
      add_acc(n, 12'h300, 2'b00, 32'h0);
      add_acc(n, 12'h300, 2'b01, m_ret(r_mstatus));
      add_acc(n, 12'h341, 2'b00, 32'h0);
      e_rpc = r_mepc;
    end
    e_rv[n+1] = 1'b1;
    e_busy[n+2] = 1'b0; e_ready[n+2] = 1'b1;
    e_len = n + 2;
  endtask

  // Present one request for one cycle, then record outputs for ncyc cycles.
  task automatic run_seq(input bit ec, input bit mr, input logic [31:0] pc,
                         input logic [31:0] cause, input int ncyc);
    @(negedge clk);
    req_valid = 1'b1; is_ecall = ec; is_mret = mr; req_pc = pc; req_cause = cause;
    @(posedge clk); #1;
    req_valid = 1'b0; is_ecall = 1'b0; is_mret = 1'b0;
    for (int c = 1; c <= ncyc; c++) begin
      if (c > 1) begin @(posedge clk); #1; end
      o_addr[c] = csr_addr; o_wen[c] = csr_wen; o_wdata[c] = csr_wdata;
      o_rv[c] = redirect_valid; o_rpc[c] = redirect_pc;
      o_busy[c] = busy; o_ready[c] = req_ready;
    end
  endtask

  task automatic test_trap_seq(input string tag, input bit ec, input bit mr,
                               input logic [31:0] pc, input logic [31:0] cause);
    build_expect(ec, mr, pc, cause);
    run_seq(ec, mr, pc, cause, e_len);
    for (int c = 1; c <= e_len; c++) begin
      n_checks++;
      if (o_wen[c] !== e_wen[c]) begin
        n_errors++;
        $display("FAIL %s c%0d csr_wen got=%b exp=%b", tag, c, o_wen[c], e_wen[c]);
      end
      if (e_chk_addr[c]) begin
        n_checks++;
        if (o_addr[c] !== e_addr[c]) begin
          n_errors++;
          $display("FAIL %s c%0d csr_addr got=%h exp=%h", tag, c, o_addr[c], e_addr[c]);
        end
      end
      if (e_wen[c] != 2'b00) begin
        n_checks++;
        if (o_wdata[c] !== e_wdata[c]) begin
          n_errors++;
          $display("FAIL %s c%0d csr_wdata got=%h exp=%h", tag, c, o_wdata[c], e_wdata[c]);
        end
      end
      n_checks++;
      if ({o_rv[c], o_busy[c], o_ready[c]} !== {e_rv[c], e_busy[c], e_ready[c]}) begin
        n_errors++;
        $display("FAIL %s c%0d rv/busy/ready got=%b%b%b exp=%b%b%b", tag, c,
                 o_rv[c], o_busy[c], o_ready[c], e_rv[c], e_busy[c], e_ready[c]);
      end
      if (e_rv[c] || c == e_len) begin
        n_checks++;
        if (o_rpc[c] !== e_rpc) begin
          n_errors++;
          $display("FAIL %s c%0d redirect_pc got=%h exp=%h", tag, c, o_rpc[c], e_rpc);
        end
      end
    end
  endtask

  task automatic test_reset;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({busy, req_ready, csr_wen, redirect_valid} !== 5'b01000) begin
      n_errors++;
      $display("FAIL reset busy/ready/wen/rv got=%b exp=01000", {busy, req_ready, csr_wen, redirect_valid});
    end
    n_checks++;
    if (csr_addr !== 12'h0) begin n_errors++; $display("FAIL reset csr_addr got=%h exp=0", csr_addr); end
    n_checks++;
    if (csr_wdata !== 32'h0) begin n_errors++; $display("FAIL reset csr_wdata got=%h exp=0", csr_wdata); end
    n_checks++;
    if (redirect_pc !== 32'h0) begin n_errors++; $display("FAIL reset redirect_pc got=%h exp=0", redirect_pc); end
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_ignored;
    @(negedge clk);
    req_valid = 1'b1; is_ecall = 1'b0; is_mret = 1'b0; req_pc = 32'h1234;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      n_checks++;
      if ({busy, req_ready, csr_wen} !== 4'b0100) begin
        n_errors++;
        $display("FAIL ignored c%0d busy/ready/wen got=%b exp=0100", c, {busy, req_ready, csr_wen});
      end
    end
    req_valid = 1'b0;
  endtask

  task automatic test_ecall;
    r_mstatus = 32'h0000_0008; r_mtvec = 32'h8000_0101;
    test_trap_seq("ecall", 1'b1, 1'b0, 32'h8000_0010, 32'h0000_000B);
    n_checks++;
    if (o_wdata[2] !== 32'h0000_1880) begin n_errors++; $display("FAIL ecall mstatus_wr got=%h exp=00001880", o_wdata[2]); end
    n_checks++;
    if (o_rv[6] !== 1'b1 || o_rpc[6] !== 32'h8000_0100) begin
      n_errors++; $display("FAIL ecall redirect c6 got=%b/%h exp=1/80000100", o_rv[6], o_rpc[6]);
    end
    n_checks++;
    if ({r_mstatus, r_mepc, r_mcause} !== {32'h0000_1880, 32'h8000_0010, 32'h0000_000B}) begin
      n_errors++; $display("FAIL ecall csr_state got=%h %h %h exp=00001880 80000010 0000000b", r_mstatus, r_mepc, r_mcause);
    end
  endtask

  task automatic test_mret;
    r_mstatus = 32'h0000_1880; r_mepc = 32'h8000_0014;
    test_trap_seq("mret", 1'b0, 1'b1, 32'h8000_0050, 32'h0);
    n_checks++;
    if (o_wdata[2] !== 32'h0000_0088) begin n_errors++; $display("FAIL mret mstatus_wr got=%h exp=00000088", o_wdata[2]); end
    n_checks++;
    if (o_rv[4] !== 1'b1 || o_rpc[4] !== 32'h8000_0014) begin
      n_errors++; $display("FAIL mret redirect c4 got=%b/%h exp=1/80000014", o_rv[4], o_rpc[4]);
    end
  endtask

  task automatic test_both_set;
    int n_epc_rd;
    r_mstatus = 32'h0000_0080; r_mtvec = 32'h8000_0200; r_mepc = 32'h1234_5678;
    test_trap_seq("both", 1'b1, 1'b1, 32'h8000_0300, 32'h0000_0007);
    n_epc_rd = 0;
    for (int c = 1; c <= e_len; c++) if (o_addr[c] == 12'h341 && o_wen[c] == 2'b00) n_epc_rd++;
    n_checks++;
    if (n_epc_rd != 0) begin n_errors++; $display("FAIL both mepc_reads got=%0d exp=0", n_epc_rd); end
  endtask

  task automatic test_random;
    int t;
    for (int i = 0; i < 24; i++) begin
      r_mstatus = $urandom; r_mtvec = $urandom; r_mepc = $urandom;
      t = $urandom_range(0, 2);
      test_trap_seq($sformatf("rand%0d", i), t != 1, t != 0, $urandom, $urandom);
    end
  endtask

  task automatic test_back_to_back;
    logic exp_busy;
    r_mstatus = 32'h0000_0008; r_mtvec = 32'h8000_0400;
    @(negedge clk);
    req_valid = 1'b1; is_ecall = 1'b1; is_mret = 1'b0;
    req_pc = 32'h8000_0A00; req_cause = 32'h0000_000B;
    @(posedge clk); #1;
    req_pc = 32'h8000_0B00;
    for (int c = 1; c <= 14; c++) begin
      if (c > 1) begin @(posedge clk); #1; end
      exp_busy = (c != 7) && (c != 14);
      n_checks++;
      if (busy !== exp_busy || req_ready !== !exp_busy) begin
        n_errors++;
        $display("FAIL b2b c%0d busy/ready got=%b%b exp=%b%b", c, busy, req_ready, exp_busy, !exp_busy);
      end
      if (c == 3 || c == 10) begin
        n_checks++;
        if (csr_addr !== 12'h341 || csr_wen !== 2'b01 ||
            csr_wdata !== ((c == 3) ? 32'h8000_0A00 : 32'h8000_0B00)) begin
          n_errors++;
          $display("FAIL b2b c%0d mepc_wr got=%h/%b/%h exp=341/01/%h", c, csr_addr, csr_wen, csr_wdata,
                   (c == 3) ? 32'h8000_0A00 : 32'h8000_0B00);
        end
      end
      if (c == 8) begin req_valid = 1'b0; is_ecall = 1'b0; end
    end
  endtask

  task automatic test_reset_mid_seq;
    r_mstatus = 32'h0000_0008; r_mepc = 32'h0000_1111; r_mcause = 32'h0000_DEAD;
    n_wr_cause = 0;
    @(negedge clk);
    req_valid = 1'b1; is_ecall = 1'b1; req_pc = 32'h8000_0040; req_cause = 32'h0000_0008;
    @(posedge clk); #1;
    req_valid = 1'b0; is_ecall = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    n_checks++;
    if (csr_addr !== 12'h341 || csr_wen !== 2'b01) begin
      n_errors++; $display("FAIL rstmid in_wr_epc got=%h/%b exp=341/01", csr_addr, csr_wen);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({busy, req_ready, csr_wen, redirect_valid} !== 5'b01000 || csr_addr !== 12'h0 ||
        csr_wdata !== 32'h0 || redirect_pc !== 32'h0) begin
      n_errors++;
      $display("FAIL rstmid async_outputs got=%b %h %h %h exp=01000 000 0 0",
               {busy, req_ready, csr_wen, redirect_valid}, csr_addr, csr_wdata, redirect_pc);
    end
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      n_checks++;
      if ({busy, req_ready, csr_wen} !== 4'b0100) begin
        n_errors++; $display("FAIL rstmid after_release got=%b exp=0100", {busy, req_ready, csr_wen});
      end
    end
    n_checks++;
    if (n_wr_cause != 0 || r_mcause !== 32'h0000_DEAD) begin
      n_errors++; $display("FAIL rstmid mcause_writes got=%0d/%h exp=0/0000dead", n_wr_cause, r_mcause);
    end
    n_checks++;
    if (r_mstatus !== 32'h0000_1880 || r_mepc !== 32'h0000_1111) begin
      n_errors++; $display("FAIL rstmid prior_writes got=%h/%h exp=00001880/00001111", r_mstatus, r_mepc);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout errors=%0d checks=%0d", n_errors, n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_ignored();
    test_ecall();
    test_mret();
    test_both_set();
    test_random();
    test_back_to_back();
    test_reset_mid_seq();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
